// File: rtl/ram_rd_ctrl_pkg.sv
// ram_rd_ctrl_pkg: FSM state encodings and stat counter width shared by the read controller.
package ram_rd_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
  localparam int STAT_W = 32;
endpackage

// File: rtl/ram_rd_buf.sv
// ram_rd_buf: register circular buffer holding captured read data until the response side pops it.
module ram_rd_buf #(
  parameter int G_WIDTH   = 16,
  parameter int G_BUF_DEP = 4,
  parameter int G_BUF_AW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [G_WIDTH-1:0]  pdat,
  input  logic                pop,
  output logic [G_WIDTH-1:0]  head,
  output logic [G_BUF_AW:0]   count
);
  logic [G_WIDTH-1:0]  mem_q [G_BUF_DEP];
  logic [G_WIDTH-1:0]  mem_d [G_BUF_DEP];
  logic [G_BUF_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [G_BUF_AW:0]   cnt_q, cnt_d;
  logic                pop_ok;
  assign pop_ok = pop & (cnt_q != '0);
  assign head   = mem_q[rd_ptr_q];
  assign count  = cnt_q;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = pdat;
    wr_ptr_d = wr_ptr_q + G_BUF_AW'(push);
    rd_ptr_d = rd_ptr_q + G_BUF_AW'(pop_ok);
    cnt_d    = cnt_q + (G_BUF_AW+1)'(push) - (G_BUF_AW+1)'(pop_ok);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
  // Credit logic upstream must make a capture into a full buffer without a pop impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop_ok && cnt_q == (G_BUF_AW+1)'(G_BUF_DEP)));
endmodule

// File: rtl/ram_rd_ctrl.sv
// ram_rd_ctrl: credit-protected RAM read controller with in-order response buffer.
// Optional stat counters enabled by defining RAM_RD_CTRL_STAT_EN.
module ram_rd_ctrl
  import ram_rd_ctrl_pkg::*;
#(
  parameter int G_ADDR    = 10,
  parameter int G_WIDTH   = 16,
  parameter int G_RD_LAT  = 1,
  parameter int G_BUF_DEP = 4,
  parameter int G_BUF_AW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ram_clrrdy,
  input  logic               req_vld,
  output logic               req_rdy,
  input  logic [G_ADDR-1:0]  req_add,
  output logic [G_ADDR-1:0]  ram_add,
  input  logic [G_WIDTH-1:0] ram_rdat,
  output logic               rsp_vld,
  input  logic               rsp_rdy,
  output logic [G_WIDTH-1:0] rsp_dat,
  output logic [STAT_W-1:0]  stat_rdcnt,
  output logic [STAT_W-1:0]  stat_stall,
  input  logic               stat_clr
);
  state_t              state_q, state_d;
  logic [G_RD_LAT:0]   sr_q, sr_d;
  logic [G_BUF_AW:0]   infl_q, infl_d, cnt;
  logic [G_ADDR-1:0]   add_q, add_d;
  logic [G_BUF_AW+1:0] outst;
  logic                acc, push, pop;
  // Same-cycle pops are deliberately not credited to keep req_rdy off the response path.
  assign outst   = {1'b0, infl_q} + {1'b0, cnt};
  assign req_rdy = (state_q == ST_RUN) && (outst < (G_BUF_AW+2)'(G_BUF_DEP));
  assign acc     = req_vld & req_rdy;
  assign push    = sr_q[G_RD_LAT];
  assign rsp_vld = cnt != '0;
  assign pop     = rsp_vld & rsp_rdy;
  assign ram_add = add_q;
  always_comb begin
    add_d  = acc ? req_add : add_q;
    sr_d   = {sr_q[G_RD_LAT-1:0], acc};
    infl_d = infl_q + (G_BUF_AW+1)'(acc) - (G_BUF_AW+1)'(push);
    state_d = state_q == ST_INIT ? (ram_clrrdy ? ST_RUN : ST_INIT)
            : state_q == ST_RUN  ? (ram_clrrdy ? ST_RUN : ST_DRAIN)
            : (infl_q == '0 ? ST_INIT : ST_DRAIN);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      sr_q    <= '0;
      infl_q  <= '0;
      add_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      infl_q  <= infl_d;
      add_q   <= add_d;
    end
  end
  ram_rd_buf #(
    .G_WIDTH  (G_WIDTH),
    .G_BUF_DEP(G_BUF_DEP),
    .G_BUF_AW (G_BUF_AW)
  ) u_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pdat (ram_rdat),
    .pop  (pop),
    .head (rsp_dat),
    .count(cnt)
  );
`ifdef RAM_RD_CTRL_STAT_EN
  logic [STAT_W-1:0] rdcnt_q, rdcnt_d, stall_q, stall_d;
  always_comb begin
    rdcnt_d = stat_clr ? '0 : (acc && ~&rdcnt_q) ? rdcnt_q + STAT_W'(1) : rdcnt_q;
    stall_d = stat_clr ? '0 : (req_vld && !req_rdy && ~&stall_q) ? stall_q + STAT_W'(1) : stall_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdcnt_q <= '0;
      stall_q <= '0;
    end else begin
      rdcnt_q <= rdcnt_d;
      stall_q <= stall_d;
    end
  end
  assign stat_rdcnt = rdcnt_q;
  assign stat_stall = stall_q;
`else
  logic stat_clr_unused;
  assign stat_clr_unused = stat_clr;
  assign stat_rdcnt = '0;
  assign stat_stall = '0;
`endif
endmodule
